// File: rtl/elastic_pipe_stage.sv
// elastic_pipe_stage: in-order valid/ready pipeline register of Depth entries with synchronous squash.
// Optional macro ELASTIC_PIPE_STATS_EN adds saturating stall and flush counters.
module elastic_pipe_stage #(
   parameter int DataWidth        = 64,
   parameter int Depth            = 2,
   parameter int ClearDataOnReset = 0,
   localparam int CntW            = $clog2(Depth + 1),
   localparam int PtrW            = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 flush_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic [DataWidth-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [CntW-1:0]      count_o
`ifdef ELASTIC_PIPE_STATS_EN
   ,
   output logic [31:0]          stall_cnt_o,
   output logic [15:0]          flush_cnt_o
`endif
);

   if (Depth < 1 || DataWidth < 1) begin : g_bad_param
      $error("elastic_pipe_stage: Depth and DataWidth must both be >= 1");
   end

   logic [DataWidth-1:0] mem_r [Depth];
   logic [PtrW-1:0]      wr_ptr_r;
   logic [PtrW-1:0]      rd_ptr_r;
   logic [CntW-1:0]      count_r;
   logic                 not_full_s;
   logic                 ready_s;
   logic                 valid_s;
   logic                 push_s;
   logic                 pop_s;

   // Pointers wrap explicitly so non-power-of-2 depths are legal.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      logic [PtrW-1:0] nxt;
      if (ptr == PtrW'(Depth - 1)) begin
         nxt = {PtrW{1'b0}};
      end else begin
         nxt = ptr + PtrW'(1);
      end
      return nxt;
   endfunction

   // Handshake decode; a same-cycle pop frees a full slot, and flush hides the head from downstream.
   always_comb begin
      not_full_s = (count_r < CntW'(Depth));
      ready_s    = not_full_s | ready_i;
      valid_s    = (count_r != {CntW{1'b0}}) & ~flush_i;
      push_s     = valid_i & ready_s & ~flush_i;
      pop_s      = valid_s & ready_i;
   end

   // Occupancy and pointer state.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_r  <= {CntW{1'b0}};
         wr_ptr_r <= {PtrW{1'b0}};
         rd_ptr_r <= {PtrW{1'b0}};
      end else if (flush_i) begin
         count_r  <= {CntW{1'b0}};
         wr_ptr_r <= {PtrW{1'b0}};
         rd_ptr_r <= {PtrW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CntW'(1);
            2'b01:   count_r <= count_r - CntW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Payload storage; only zeroed on reset when the instance asks for it.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         if (ClearDataOnReset != 0) begin
            for (int i = 0; i < Depth; i++) begin
               mem_r[i] <= {DataWidth{1'b0}};
            end
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= data_i;
      end
   end

   assign ready_o = ready_s;
   assign valid_o = valid_s;
   assign data_o  = mem_r[rd_ptr_r];
   assign count_o = count_r;

`ifdef ELASTIC_PIPE_STATS_EN
   logic [31:0] stall_cnt_r;
   logic [15:0] flush_cnt_r;

   // Saturating statistics, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 16'd0;
      end else begin
         if (valid_s && !ready_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end
         if (flush_i && (count_r != {CntW{1'b0}}) && (flush_cnt_r != 16'hFFFF)) begin
            flush_cnt_r <= flush_cnt_r + 16'd1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_r;
   assign flush_cnt_o = flush_cnt_r;
`endif

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Scoreboard bench for elastic_pipe_stage: instance 0 is Depth=2 with cleared data, instance 1 is Depth=3.
module tb_elastic_pipe_stage;

   logic       clk;
   logic       rst  [2];
   logic       f_i  [2];
   logic       v_i  [2];
   logic       r_i  [2];
   logic [7:0] d_i  [2];
   logic       ro   [2];
   logic       vo   [2];
   logic [7:0] d_o  [2];
   logic [1:0] cnt  [2];
`ifdef ELASTIC_PIPE_STATS_EN
   logic [31:0] stall [2];
   logic [15:0] fcnt  [2];
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int mcnt [2];
   int depth_of [2];
   logic [7:0] q0[$], q1[$], outs0[$], outs1[$], exp_q[$];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      elastic_pipe_stage #(
         .DataWidth(8),
         .Depth((g == 0) ? 2 : 3),
         .ClearDataOnReset((g == 0) ? 1 : 0)
      ) u_dut (
         .clk_i(clk), .reset_i(rst[g]), .flush_i(f_i[g]), .data_i(d_i[g]), .valid_i(v_i[g]),
         .ready_o(ro[g]), .data_o(d_o[g]), .valid_o(vo[g]), .ready_i(r_i[g]), .count_o(cnt[g])
`ifdef ELASTIC_PIPE_STATS_EN
         , .stall_cnt_o(stall[g]), .flush_cnt_o(fcnt[g])
`endif
      );
   end

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: checks handshake outputs against a count model and pops the scoreboard on every transfer.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         logic e_rdy, e_vld, pu, po;
         logic [7:0] e;
         e_rdy = (mcnt[g] < depth_of[g]) || r_i[g];
         e_vld = (mcnt[g] != 0) && !f_i[g];
         chk($sformatf("rdy%0d", g), {31'd0, ro[g]}, {31'd0, e_rdy});
         chk($sformatf("vld%0d", g), {31'd0, vo[g]}, {31'd0, e_vld});
         chk($sformatf("cnt%0d", g), {30'd0, cnt[g]}, mcnt[g]);
         po = e_vld && r_i[g];
         pu = v_i[g] && e_rdy && !f_i[g];
         if (po) begin
            if (g == 0) begin
               outs0.push_back(d_o[g]);
               e = (q0.size() > 0) ? q0.pop_front() : 8'hxx;
            end else begin
               outs1.push_back(d_o[g]);
               e = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
            end
            chk($sformatf("data%0d", g), {24'd0, d_o[g]}, {24'd0, e});
         end
         if (rst[g] || f_i[g]) begin
            mcnt[g] = 0;
            if (g == 0) q0.delete(); else q1.delete();
         end else begin
            if (pu) begin
               if (g == 0) q0.push_back(d_i[g]); else q1.push_back(d_i[g]);
            end
            mcnt[g] = mcnt[g] + (pu ? 1 : 0) - (po ? 1 : 0);
         end
      end
   end

   task automatic drive(input int g, input logic v, input logic [7:0] d, input logic r,
                        input logic f, input logic rs);
      v_i[g] = v; d_i[g] = d; r_i[g] = r; f_i[g] = f; rst[g] = rs;
      @(posedge clk); #1;
   endtask

   task automatic check_outs(input int g, input string name);
      logic [7:0] got[$];
      if (g == 0) begin got = outs0; outs0.delete(); end
      else begin got = outs1; outs1.delete(); end
      chk({name, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("%s_%0d", name, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
   endtask

   initial begin
      int k, cyc;
      logic tog, acc;
      clk = 1'b0;
      depth_of[0] = 2; depth_of[1] = 3;
      for (int g = 0; g < 2; g++) begin
         mcnt[g] = 0; rst[g] = 1'b1; f_i[g] = 1'b0; v_i[g] = 1'b0; r_i[g] = 1'b0; d_i[g] = 8'h00;
      end
      @(posedge clk); @(posedge clk); #1;
      rst[0] = 1'b0; rst[1] = 1'b0;
      chk("reset_cnt", {30'd0, cnt[0]}, 32'd0);
      chk("reset_data", {24'd0, d_o[0]}, 32'd0);

      // 1: fill with ready low, then drain in order.
      drive(0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
      v_i[0] = 1'b0; #1;
      chk("t1_full_cnt", {30'd0, cnt[0]}, 32'd2);
      chk("t1_full_rdy", {31'd0, ro[0]}, 32'd0);
      drive(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t1_cnt1", {30'd0, cnt[0]}, 32'd1);
      drive(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t1_cnt0", {30'd0, cnt[0]}, 32'd0);
      exp_q = '{8'hA1, 8'hB2};
      check_outs(0, "t1_order");

      // 2: full with simultaneous push and pop.
      drive(0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
      d_i[0] = 8'hC3; r_i[0] = 1'b1; #1;
      chk("t2_rdy_full", {31'd0, ro[0]}, 32'd1);
      @(posedge clk); #1;
      chk("t2_cnt_stay", {30'd0, cnt[0]}, 32'd2);
      drive(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      drive(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t2_cnt0", {30'd0, cnt[0]}, 32'd0);
      exp_q = '{8'hA1, 8'hB2, 8'hC3};
      check_outs(0, "t2_order");
      drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // 3: Depth=3 wrap with ready toggling; upstream holds a beat until accepted.
      k = 1; cyc = 0; tog = 1'b0;
      while (k <= 7 && cyc < 60) begin
         v_i[1] = 1'b1; d_i[1] = 8'(k); r_i[1] = tog; tog = ~tog;
         @(negedge clk); acc = ro[1];
         @(posedge clk); #1;
         if (acc) k++;
         cyc++;
      end
      chk("t3_all_pushed", k, 32'd8);
      v_i[1] = 1'b0; r_i[1] = 1'b1; cyc = 0;
      while (cnt[1] != 2'd0 && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("t3_drained", {30'd0, cnt[1]}, 32'd0);
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      check_outs(1, "t3_order");
      r_i[1] = 1'b0;

      // 4: flush with two entries and a live input beat.
      drive(0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      d_i[0] = 8'hEE; r_i[0] = 1'b1; f_i[0] = 1'b1; #1;
      chk("t4_vld_flush", {31'd0, vo[0]}, 32'd0);
      chk("t4_rdy_flush", {31'd0, ro[0]}, 32'd1);
      @(posedge clk); #1;
      f_i[0] = 1'b0; v_i[0] = 1'b0; #1;
      chk("t4_cnt0", {30'd0, cnt[0]}, 32'd0);
      chk("t4_vld0", {31'd0, vo[0]}, 32'd0);
      drive(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      drive(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      exp_q.delete();
      check_outs(0, "t4_none");

      // 5: reset together with flush while holding two entries.
      drive(0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
      rst[0] = 1'b0; f_i[0] = 1'b0; v_i[0] = 1'b0; r_i[0] = 1'b0; #1;
      chk("t5_vld", {31'd0, vo[0]}, 32'd0);
      chk("t5_rdy", {31'd0, ro[0]}, 32'd1);
      chk("t5_data", {24'd0, d_o[0]}, 32'd0);
      chk("t5_cnt", {30'd0, cnt[0]}, 32'd0);
      drive(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      exp_q.delete();
      check_outs(0, "t5_none");

`ifdef ELASTIC_PIPE_STATS_EN
      // 6: five stalled cycles then one flush of a live entry.
      drive(0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      f_i[0] = 1'b0; #1;
      chk("t6_stall", stall[0], 32'd5);
      chk("t6_flush", {16'd0, fcnt[0]}, 32'd1);
`endif

      drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
